keccak_byte_packer: RTL and testbench
=====================================

# keccak_byte_packer

Upstream feeder for the `keccak` hash core. It collects a byte stream from the UART receive path into big-endian 32-bit words and presents them on the core's word interface: `in`, `in_ready`, `is_last`, `byte_num` and `buffer_full`. It generates the end-of-message framing the core's padder expects, including the zero-byte terminating word. After one message it holds off all further input until reset.

## Interface
Parameters: none (word width fixed at 32, byte width at 8).

- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- byte_in  input  8  message byte from UART RX
- byte_valid  input  1  byte_in valid this cycle
- byte_last  input  1  qualifies byte_in as final message byte; ignored unless byte_valid
- msg_end  input  1  1-cycle strobe: end message with no accompanying byte (allows empty or word-aligned ending)
- byte_ready  output  1  packer accepts a byte or msg_end this cycle
- word_out  output  32  to keccak `in`; first byte of word in [31:24]
- word_valid  output  1  to keccak `in_ready`
- word_last  output  1  to keccak `is_last`; only ever high with word_valid
- word_byte_num  output  2  to keccak `byte_num`; valid bytes in the last word (0..3); 0 when word_last low
- buffer_full  input  1  from keccak; word accepted on a cycle with word_valid && !buffer_full
- msg_done  output  1  last word has been accepted; held until reset

## Operation
- Registers: `state`, `cnt[1:0]` (bytes held), `word[31:0]`.
- States:
  - FILL: byte_ready=1, word_valid=0.
  - FULL: word_valid=1, word_last=0.
  - FULL_THEN_LAST: word_valid=1, word_last=0.
  - LAST: word_valid=1, word_last=1, word_byte_num=cnt.
  - DONE: byte_ready=0, word_valid=0, msg_done=1.
- Byte accept = byte_valid && byte_ready. The byte is written to word[31-8*cnt -: 8], and cnt increments (wraps 3→0).
- FILL transitions, in priority order:
  - Byte accepted with byte_last (or with msg_end on the same cycle, which is treated as byte_last): if cnt==3 → FULL_THEN_LAST, else → LAST with cnt+1.
  - Byte accepted without last: if cnt==3 → FULL, else stay in FILL.
  - msg_end alone → LAST with current cnt (0..3).
  - msg_end outside FILL is ignored.
- FULL: on word accept, clear word, cnt=0 → FILL.
- FULL_THEN_LAST: on word accept, clear word, cnt=0 → LAST. This emits the terminator word with word_byte_num=0, word_out=0.
- LAST: on word accept → DONE.
- DONE: absorbing state until reset. byte_valid and msg_end are ignored; no word is ever emitted.
- Unfilled byte lanes of word_out are always 0.
- word_out, word_last and word_byte_num are stable while word_valid && buffer_full (stall).

## Timing
- Reset values: byte_ready=1 (state FILL), word_valid=0, word_last=0, word_byte_num=0, word_out=0, msg_done=0, cnt=0.
- All outputs are functions of registers only (Moore); no combinational path from inputs to outputs.
- A 4th byte or a last byte accepted at edge N gives word_valid=1 from cycle N+1.
- A word accepted at edge M gives word_valid=0 and byte_ready=1 at M+1 (FULL→FILL).
- FULL_THEN_LAST→LAST gives word_valid continuously high, with the terminator word at M+1.
- No bytes are accepted while any word is pending; byte_ready=0 in FULL, FULL_THEN_LAST, LAST and DONE.
- Minimum per full word: 4 byte cycles + 1 transfer cycle. Unbounded stall under buffer_full.
- reset asserted in any state (including mid-word or during a stall) returns to reset values at the next edge. The partial word is discarded.

## Test plan
- Bytes 0x61,0x62,0x63 ("abc"), last on 0x63, buffer_full=0 → one word 0x61626300, word_last=1, word_byte_num=3. msg_done=1 the cycle after acceptance.
- 4 bytes 0x01..0x04, last on 0x04 → word 0x01020304 (last=0), then word 0x00000000, last=1, byte_num=0, in back-to-back cycles.
- Empty message (msg_end pulse after reset) → single word 0x00000000, last=1, byte_num=0. byte_ready low from the next cycle.
- 9 bytes with buffer_full held high 10 cycles on the second word → that word is held stable and accepted on the first !buffer_full cycle. The third word is 0x09000000, byte_num=1.
- Bytes and msg_end after msg_done → no word_valid, byte_ready=0. Then reset → byte_ready=1, all outputs at reset values, and a new "abc" message succeeds.
- Reset after 2 of 4 bytes → the next 4 bytes form a clean word with no residue from the discarded bytes.

Source files
------------

// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer
// Packs a UART byte stream into big-endian 32-bit words for the keccak core.
// It emits the end-of-message framing the padder expects: the last word is
// flagged with its valid byte count, and a word-aligned message gets an
// extra all-zero terminator word. After one message the packer ignores all
// input until reset.
module keccak_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    input  logic        msg_end,
    output logic        byte_ready,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        word_last,
    output logic [1:0]  word_byte_num,
    input  logic        buffer_full,
    output logic        msg_done
);

    typedef enum logic [2:0] {
        S_FILL           = 3'd0,
        S_FULL           = 3'd1,
        S_FULL_THEN_LAST = 3'd2,
        S_LAST           = 3'd3,
        S_DONE           = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        word_take_s;

    // Places a byte in the lane selected by the current fill count; lane 0
    // is the most significant byte so the stream lands big-endian.
    function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            2'd3:    r[7:0]   = b;
            default: r        = w;
        endcase
        return r;
    endfunction

    // The core takes a pending word on any cycle it is not signalling full.
    assign word_take_s = !buffer_full;

    // Next-state logic: byte collection, end-of-message framing and handoff.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        case (state_q)
            S_FILL: begin
                if (byte_valid) begin
                    word_d = insert_byte(word_q, cnt_q, byte_in);
                    cnt_d  = cnt_q + 2'd1;
                    // A coincident msg_end makes this byte the final one.
                    if (byte_last || msg_end) begin
                        if (cnt_q == 2'd3) begin
                            state_d = S_FULL_THEN_LAST;
                        end else begin
                            state_d = S_LAST;
                        end
                    end else begin
                        if (cnt_q == 2'd3) begin
                            state_d = S_FULL;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end else if (msg_end) begin
                    state_d = S_LAST;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FULL: begin
                if (word_take_s) begin
                    word_d  = 32'h0000_0000;
                    cnt_d   = 2'd0;
                    state_d = S_FILL;
                end else begin
                    state_d = S_FULL;
                end
            end
            S_FULL_THEN_LAST: begin
                // Clearing the word here produces the zero terminator.
                if (word_take_s) begin
                    word_d  = 32'h0000_0000;
                    cnt_d   = 2'd0;
                    state_d = S_LAST;
                end else begin
                    state_d = S_FULL_THEN_LAST;
                end
            end
            S_LAST: begin
                if (word_take_s) begin
                    word_d  = 32'h0000_0000;
                    cnt_d   = 2'd0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_LAST;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_FILL;
                cnt_d   = 2'd0;
                word_d  = 32'h0000_0000;
            end
        endcase
    end

    // State, fill count and word registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            cnt_q   <= 2'd0;
            word_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // Moore outputs decoded from the registered state only.
    assign byte_ready    = (state_q == S_FILL);
    assign word_valid    = (state_q == S_FULL) || (state_q == S_FULL_THEN_LAST) ||
                           (state_q == S_LAST);
    assign word_last     = (state_q == S_LAST);
    assign word_byte_num = (state_q == S_LAST) ? cnt_q : 2'd0;
    assign word_out      = word_q;
    assign msg_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Bench for keccak_byte_packer: a message-level model turns each message into
// its expected word list; one compare process checks every output cycle.
module tb_keccak_byte_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        msg_end;
    logic        byte_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_last;
    logic [1:0]  word_byte_num;
    logic        buffer_full;
    logic        msg_done;

    keccak_byte_packer dut (
        .clk           (clk),
        .reset         (reset),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_last     (byte_last),
        .msg_end       (msg_end),
        .byte_ready    (byte_ready),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .word_last     (word_last),
        .word_byte_num (word_byte_num),
        .buffer_full   (buffer_full),
        .msg_done      (msg_done)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  bnum;
    } wexp_t;

    wexp_t       expq[$];
    logic [7:0]  msgq[$];
    logic [31:0] acc_data[$];
    int          acc_cyc[$];
    bit          done_exp;
    int          cyc;
    int          pass_cnt;
    int          total_cnt;
    int          release_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Message model: full 4-byte chunks, then either a partial last word with
    // its byte count or, if the length is a multiple of 4, a zero terminator.
    task automatic model_push(input int n);
        int    full;
        int    rem;
        wexp_t e;
        full = n / 4;
        rem  = n % 4;
        for (int w = 0; w < full; w++) begin
            e.data = 32'h0;
            for (int k = 0; k < 4; k++)
                e.data = e.data | (32'(msgq[4*w+k]) << (24 - 8*k));
            e.last = 1'b0;
            e.bnum = 2'd0;
            expq.push_back(e);
        end
        e.data = 32'h0;
        for (int k = 0; k < rem; k++)
            e.data = e.data | (32'(msgq[4*full+k]) << (24 - 8*k));
        e.last = 1'b1;
        e.bnum = 2'(rem);
        expq.push_back(e);
    endtask

    // Per-cycle output comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            if (word_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    check("word_out", word_out, expq[0].data);
                    check("word_last", 32'(word_last), 32'(expq[0].last));
                    check("word_byte_num", 32'(word_byte_num), 32'(expq[0].bnum));
                end
            end else begin
                check("idle_last", 32'(word_last), 32'd0);
                check("idle_bnum", 32'(word_byte_num), 32'd0);
            end
            check("msg_done", 32'(msg_done), 32'(done_exp));
            check("byte_ready", 32'(byte_ready), 32'(!word_valid && !done_exp));
        end
    end

    // Word handshake tracking: pops the model on each accepted word.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            expq.delete();
            done_exp <= 1'b0;
        end else if (word_valid && !buffer_full && expq.size() > 0) begin
            acc_data.push_back(word_out);
            acc_cyc.push_back(cyc);
            if (expq[0].last) done_exp <= 1'b1;
            void'(expq.pop_front());
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; byte_valid = 1'b0; byte_last = 1'b0; msg_end = 1'b0;
        byte_in = 8'h00; buffer_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_last", 32'(word_last), 32'd0);
        check("rst_byte_num", 32'(word_byte_num), 32'd0);
        check("rst_word_out", word_out, 32'h0);
        check("rst_msg_done", 32'(msg_done), 32'd0);
        acc_data.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (!byte_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = byte_ready;
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            byte_in = b; byte_valid = 1'b1; byte_last = last;
            @(negedge clk);
            byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
        end
    endtask

    task automatic send_end();
        bit ok;
        wait_ready(ok);
        if (ok) begin
            msg_end = 1'b1;
            @(negedge clk);
            msg_end = 1'b0;
        end
    endtask

    task automatic send_message(input int n, input bit use_end);
        model_push(n);
        for (int i = 0; i < n; i++)
            send_byte(msgq[i], (i == n - 1) && !use_end);
        if (use_end) send_end();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!msg_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", 32'(msg_done), 32'd1);
        check("model_drained", 32'(expq.size()), 32'd0);
    endtask

    task automatic load_abc();
        msgq.delete();
        msgq.push_back(8'h61); msgq.push_back(8'h62); msgq.push_back(8'h63);
    endtask

    task automatic load_seq(input logic [7:0] first, input int n);
        msgq.delete();
        for (int i = 0; i < n; i++) msgq.push_back(first + 8'(i));
    endtask

    task automatic stall_ctl();
        int          t;
        logic [31:0] held;
        t = 0;
        while (acc_data.size() < 1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        buffer_full = 1'b1;
        t = 0;
        while (!word_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("stall_word_seen", 32'(word_valid), 32'd1);
        held = word_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold_valid", 32'(word_valid), 32'd1);
            check("stall_hold_data", word_out, held);
        end
        release_cyc = cyc;
        buffer_full = 1'b0;
    endtask

    initial begin
        reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
        msg_end = 1'b0; buffer_full = 1'b0;
        pass_cnt = 0; total_cnt = 0; cyc = 0; done_exp = 1'b0; release_cyc = -1;

        // Pin the model with hand-computed framings before any clock edge.
        load_abc();
        model_push(3);
        check("model_abc_size", 32'(expq.size()), 32'd1);
        check("model_abc_data", expq[0].data, 32'h6162_6300);
        check("model_abc_bnum", 32'(expq[0].bnum), 32'd3);
        expq.delete();
        load_seq(8'h01, 4);
        model_push(4);
        check("model_4_w0", expq[0].data, 32'h0102_0304);
        check("model_4_term", expq[1].data, 32'h0000_0000);
        check("model_4_termlast", 32'(expq[1].last), 32'd1);
        expq.delete();

        // "abc" with byte_last on the final byte.
        apply_reset();
        load_abc();
        send_message(3, 1'b0);
        wait_done();
        check("abc_word", acc_data.size() > 0 ? acc_data[0] : 32'hdead_beef, 32'h6162_6300);

        // Inputs after completion are ignored.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            byte_valid = 1'b1; byte_in = 8'h55; byte_last = i[0]; msg_end = ~i[0];
            check("done_byte_ready", 32'(byte_ready), 32'd0);
            check("done_word_valid", 32'(word_valid), 32'd0);
        end
        @(negedge clk);
        byte_valid = 1'b0; byte_last = 1'b0; msg_end = 1'b0;
        check("done_hold", 32'(msg_done), 32'd1);

        // Reset restores service and a second "abc" succeeds.
        apply_reset();
        load_abc();
        send_message(3, 1'b0);
        wait_done();
        check("abc2_word", acc_data.size() > 0 ? acc_data[0] : 32'hdead_beef, 32'h6162_6300);

        // Word-aligned message: full word then terminator back-to-back.
        apply_reset();
        load_seq(8'h01, 4);
        send_message(4, 1'b0);
        wait_done();
        check("aligned_count", 32'(acc_data.size()), 32'd2);
        if (acc_data.size() == 2) begin
            check("aligned_w0", acc_data[0], 32'h0102_0304);
            check("aligned_term", acc_data[1], 32'h0000_0000);
            check("aligned_b2b", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        end

        // Empty message via msg_end.
        apply_reset();
        msgq.delete();
        model_push(0);
        send_end();
        check("empty_ready_low", 32'(byte_ready), 32'd0);
        check("empty_valid", 32'(word_valid), 32'd1);
        wait_done();
        check("empty_word", acc_data.size() > 0 ? acc_data[0] : 32'hdead_beef, 32'h0000_0000);

        // Nine bytes with a 10-cycle stall on the second word.
        apply_reset();
        load_seq(8'h01, 9);
        fork
            send_message(9, 1'b0);
            stall_ctl();
        join
        wait_done();
        check("stall_count", 32'(acc_data.size()), 32'd3);
        if (acc_data.size() == 3) begin
            check("stall_w1", acc_data[1], 32'h0506_0708);
            check("stall_accept_cyc", 32'(acc_cyc[1]), 32'(release_cyc));
            check("stall_w2", acc_data[2], 32'h0900_0000);
        end

        // msg_end after three bytes is equivalent to byte_last on the third.
        apply_reset();
        load_seq(8'h41, 3);
        send_message(3, 1'b1);
        wait_done();
        check("end3_word", acc_data.size() > 0 ? acc_data[0] : 32'hdead_beef, 32'h4142_4300);

        // Reset mid-word discards partial bytes.
        apply_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        apply_reset();
        load_seq(8'h11, 4);
        send_message(4, 1'b0);
        wait_done();
        check("clean_count", 32'(acc_data.size()), 32'd2);
        check("clean_w0", acc_data.size() > 0 ? acc_data[0] : 32'hdead_beef, 32'h1112_1314);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
